// File: rtl/ra_sched_pkg.sv
// Shared FSM state type and default sizing constants for the averager sample scheduler.
`timescale 1ns/1ps
package ra_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_FLUSH   = 3'd4
    } state_e;

    localparam int DEF_NUM_SRC       = 4;
    localparam int DEF_BITS_PER_ELEM = 5;
    localparam int DEF_RA_SIZE       = 8;
    localparam int DEF_STROBE_CYCLES = 2;
    localparam int FLUSH_CYCLES      = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the priority pointer, wrapping.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int j;

    // Walk offsets from the far end down so the nearest hit to ptr is the last write.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        grant[idx] = valid;
    end

endmodule

// File: rtl/ra_sample_sched.sv
// Schedules per-source samples into a running averager: round-robin grant, registered
// strobe/clear/ack generation, saturating fill count and deferred flush handling.
`timescale 1ns/1ps
module ra_sample_sched
    import ra_sched_pkg::*;
#(
    parameter int NUM_SRC       = DEF_NUM_SRC,
    parameter int BITS_PER_ELEM = DEF_BITS_PER_ELEM,
    parameter int RA_SIZE       = DEF_RA_SIZE,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_SRC-1:0]                 src_req,
    input  logic [NUM_SRC*BITS_PER_ELEM-1:0]   src_value,
    input  logic                               flush,
    output logic [NUM_SRC-1:0]                 src_ack,
    output logic [BITS_PER_ELEM-1:0]           ra_value,
    output logic                               ra_data_clk,
    output logic                               ra_rst,
    output logic                               busy,
    output logic [$clog2(RA_SIZE+1)-1:0]       fill_count,
    output logic                               window_full
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(RA_SIZE + 1);
    localparam int TMR_MAX = (STROBE_CYCLES > FLUSH_CYCLES) ? STROBE_CYCLES : FLUSH_CYCLES;
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [NUM_SRC-1:0]       gnt_q, gnt_d;
    logic [BITS_PER_ELEM-1:0] value_q, value_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic [CNT_W-1:0]         fill_q, fill_d;
    logic                     pend_q, pend_d;
    logic                     dclk_q, dclk_d;
    logic                     rarst_q, rarst_d;
    logic [NUM_SRC-1:0]       ack_q, ack_d;

    logic [BITS_PER_ELEM-1:0] src_lane [NUM_SRC];
    logic [NUM_SRC-1:0]       arb_gnt;
    logic [IDX_W-1:0]         arb_idx;
    logic                     arb_valid;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lane
        assign src_lane[gi] = src_value[gi*BITS_PER_ELEM +: BITS_PER_ELEM];
    end

    rr_arbiter #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (src_req),
        .ptr   (ptr_q),
        .grant (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        value_d = value_q;
        tmr_d   = tmr_q;
        fill_d  = fill_q;
        pend_d  = pend_q | flush;

        unique case (state_q)
            ST_IDLE: begin
                // A flush seen this very cycle already outranks any request.
                if (pend_q || flush) begin
                    state_d = ST_FLUSH;
                    tmr_d   = TMR_W'(FLUSH_CYCLES - 1);
                end else if (arb_valid) begin
                    state_d = ST_SETUP;
                    gnt_d   = arb_gnt;
                    value_d = src_lane[arb_idx];
                    ptr_d   = (arb_idx == IDX_W'(NUM_SRC - 1)) ? '0 : arb_idx + 1'b1;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                tmr_d   = TMR_W'(STROBE_CYCLES - 1);
            end
            ST_STROBE: begin
                if (tmr_q == '0) begin
                    state_d = ST_RELEASE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                if (fill_q != CNT_W'(RA_SIZE)) begin
                    fill_d = fill_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                fill_d = '0;
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                    // A pulse landing on the exit cycle survives for another FLUSH.
                    pend_d  = flush;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobe, clear and ack are registered copies of the upcoming state.
        dclk_d  = (state_d == ST_STROBE);
        rarst_d = (state_d == ST_FLUSH);
        ack_d   = (state_d == ST_RELEASE) ? gnt_q : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            value_q <= '0;
            tmr_q   <= '0;
            fill_q  <= '0;
            pend_q  <= 1'b0;
            dclk_q  <= 1'b0;
            rarst_q <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            value_q <= value_d;
            tmr_q   <= tmr_d;
            fill_q  <= fill_d;
            pend_q  <= pend_d;
            dclk_q  <= dclk_d;
            rarst_q <= rarst_d;
            ack_q   <= ack_d;
        end
    end

    assign src_ack     = ack_q;
    assign ra_value    = value_q;
    assign ra_data_clk = dclk_q;
    assign ra_rst      = rarst_q;
    assign busy        = (state_q != ST_IDLE);
    assign fill_count  = fill_q;
    assign window_full = (fill_q == CNT_W'(RA_SIZE));

endmodule

// File: tb/tb_ra_sample_sched.sv
// Directed bench for ra_sample_sched with an ack scoreboard (expected source/value per grant).
`timescale 1ns/1ps
module tb_ra_sample_sched;

    localparam int N  = 4;
    localparam int B  = 5;
    localparam int RS = 8;
    localparam int SC = 2;
    localparam int PERIOD = SC + 3;

    logic           clk;
    logic           rst;
    logic [N-1:0]   src_req;
    logic [N*B-1:0] src_value;
    logic           flush;
    logic [N-1:0]   src_ack;
    logic [B-1:0]   ra_value;
    logic           ra_data_clk;
    logic           ra_rst;
    logic           busy;
    logic [3:0]     fill_count;
    logic           window_full;

    typedef struct packed {
        logic [N-1:0] ack;
        logic [B-1:0] val;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   last_ack;
    int   rst_cnt;

    ra_sample_sched #(
        .NUM_SRC       (N),
        .BITS_PER_ELEM (B),
        .RA_SIZE       (RS),
        .STROBE_CYCLES (SC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_req     (src_req),
        .src_value   (src_value),
        .flush       (flush),
        .src_ack     (src_ack),
        .ra_value    (ra_value),
        .ra_data_clk (ra_data_clk),
        .ra_rst      (ra_rst),
        .busy        (busy),
        .fill_count  (fill_count),
        .window_full (window_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_val(input int src, input int v);
        src_value[src*B +: B] = B'(v);
    endtask

    task automatic push_exp(input int src, input int v);
        exp_t e;
        e.ack = N'(1) << src;
        e.val = B'(v);
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input int max_cyc);
        int n = 0;
        do begin
            tick();
            n++;
        end while (src_ack == '0 && n < max_cyc);
        check("ack_arrives", 32'(src_ack != '0), 32'd1);
    endtask

    task automatic wait_dclk(input int max_cyc);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!ra_data_clk && n < max_cyc);
        check("strobe_arrives", 32'(ra_data_clk), 32'd1);
    endtask

    task automatic count_rst(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (ra_rst) cnt++;
        end
    endtask

    // Scoreboard: every ack must match the next expected grant in order.
    always @(negedge clk) begin
        if (rst && src_ack != '0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'(src_ack), 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check("ack_source", 32'(src_ack), 32'(sb_e.ack));
                check("ack_value", 32'(ra_value), 32'(sb_e.val));
                $display("ack cycle %0d src_ack %b ra_value %0d fill %0d", cyc, src_ack, ra_value, fill_count);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        src_req = '0;
        src_value = '0;
        flush = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dclk", 32'(ra_data_clk), 32'd0);
        check("rst_rarst", 32'(ra_rst), 32'd0);
        check("rst_ack", 32'(src_ack), 32'd0);
        check("rst_fill", 32'(fill_count), 32'd0);
        check("rst_value", 32'(ra_value), 32'd0);
        check("rst_full", 32'(window_full), 32'd0);
        rst = 1'b1;
        tick();

        // Single request: cycle-exact latency
        set_val(0, 19);
        push_exp(0, 19);
        src_req = 4'b0001;
        tick();
        check("single_setup_busy", 32'(busy), 32'd1);
        check("single_setup_dclk", 32'(ra_data_clk), 32'd0);
        check("single_value", 32'(ra_value), 32'd19);
        tick();
        check("single_strobe1", 32'(ra_data_clk), 32'd1);
        tick();
        check("single_strobe2", 32'(ra_data_clk), 32'd1);
        tick();
        check("single_ack", 32'(src_ack), 32'b0001);
        check("single_release_dclk", 32'(ra_data_clk), 32'd0);
        src_req = '0;
        tick();
        check("single_idle", 32'(busy), 32'd0);
        check("single_fill", 32'(fill_count), 32'd1);

        // All sources requesting: round robin, throughput, saturation
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < N; i++) set_val(i, 3 + 7 * i);
        for (int t = 0; t < 9; t++) push_exp(t % N, 3 + 7 * (t % N));
        src_req = 4'b1111;
        last_ack = 0;
        for (int t = 0; t < 9; t++) begin
            wait_ack(3 * PERIOD);
            if (t > 0) check("ack_interval", 32'(cyc - last_ack), 32'(PERIOD));
            last_ack = cyc;
            if (t == 8) src_req = '0;
            tick();
            if (t == 6) check("full_before", 32'(window_full), 32'd0);
            if (t == 7) begin
                check("fill_eight", 32'(fill_count), 32'd8);
                check("full_after8", 32'(window_full), 32'd1);
            end
            if (t == 8) check("fill_saturate", 32'(fill_count), 32'd8);
        end

        // Flush during STROBE: ack first, then one 2-cycle clear
        set_val(1, 21);
        push_exp(1, 21);
        src_req = 4'b0010;
        wait_dclk(10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_ack(10);
        src_req = '0;
        count_rst(8, rst_cnt);
        check("flush_rst_cycles", 32'(rst_cnt), 32'd2);
        check("flush_fill", 32'(fill_count), 32'd0);
        check("flush_full", 32'(window_full), 32'd0);

        // Two pulses before service collapse to one FLUSH
        set_val(2, 6);
        push_exp(2, 6);
        src_req = 4'b0100;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("dbl_ack", 32'(src_ack), 32'b0100);
        src_req = '0;
        count_rst(10, rst_cnt);
        check("dbl_rst_cycles", 32'(rst_cnt), 32'd2);
        check("dbl_fill", 32'(fill_count), 32'd0);

        // Flush and request in the same IDLE cycle: FLUSH first
        set_val(2, 13);
        push_exp(2, 13);
        flush = 1'b1;
        src_req = 4'b0100;
        tick();
        flush = 1'b0;
        check("fr_rst1", 32'(ra_rst), 32'd1);
        check("fr_dclk", 32'(ra_data_clk), 32'd0);
        tick();
        check("fr_rst2", 32'(ra_rst), 32'd1);
        tick();
        check("fr_idle", 32'(busy), 32'd0);
        check("fr_rst_off", 32'(ra_rst), 32'd0);
        tick();
        check("fr_setup_value", 32'(ra_value), 32'd13);
        wait_ack(10);
        src_req = '0;
        tick();

        // Flush on the FLUSH exit cycle re-arms a second FLUSH
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("exit_gap", 32'(ra_rst), 32'd0);
        count_rst(6, rst_cnt);
        check("exit_second_flush", 32'(rst_cnt), 32'd2);

        // Value change and request drop mid-transfer; an ungranted requester withdraws
        set_val(3, 9);
        push_exp(3, 9);
        src_req = 4'b1000;
        wait_dclk(10);
        set_val(3, 25);
        src_req = 4'b0001;
        tick();
        check("hold_value_strobe", 32'(ra_value), 32'd9);
        src_req = '0;
        wait_ack(10);
        check("hold_value_release", 32'(ra_value), 32'd9);
        repeat (6) tick();
        check("withdrawn_idle", 32'(busy), 32'd0);

        // Reset during STROBE aborts immediately
        set_val(1, 30);
        src_req = 4'b0010;
        wait_dclk(10);
        rst = 1'b0;
        #1;
        check("abort_dclk", 32'(ra_data_clk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(src_ack), 32'd0);
        tick();
        tick();
        src_req = '0;
        rst = 1'b1;
        tick();
        check("abort_fill", 32'(fill_count), 32'd0);

        // Pointer back at 0: source 0 wins over source 3
        set_val(0, 4);
        set_val(3, 8);
        push_exp(0, 4);
        src_req = 4'b1001;
        wait_ack(10);
        src_req = '0;
        tick();
        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ra_sample_sched.md
RA_SAMPLE_SCHED -- requirements
Module: ra_sample_sched

Interface
REQ-001 Parameter NUM_SRC, default 4: number of sample requesters.
REQ-002 Parameter BITS_PER_ELEM, default 5: sample width, equal to the averager element width.
REQ-003 Parameter RA_SIZE, default 8: averager window depth, used for the fill count.
REQ-004 Parameter STROBE_CYCLES, default 2, minimum 1: high time of the averager data strobe, in clk cycles.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low.
REQ-007 src_req  in  NUM_SRC  per-source sample request, level, held until the matching ack.
REQ-008 src_value  in  NUM_SRC*BITS_PER_ELEM  per-source sample; source i occupies bits [i*BITS_PER_ELEM +: BITS_PER_ELEM].
REQ-009 flush  in  1  one-cycle pulse requesting an averager clear.
REQ-010 src_ack  out  NUM_SRC  one-hot, one-cycle pulse: the sample from that source has been consumed.
REQ-011 ra_value  out  BITS_PER_ELEM  sample driven to the averager value input.
REQ-012 ra_data_clk  out  1  data strobe to the averager; the averager captures on its rising edge.
REQ-013 ra_rst  out  1  active-high clear to the averager.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 fill_count  out  clog2(RA_SIZE+1)  number of samples loaded since the last reset or flush, saturating.
REQ-016 window_full  out  1  high while fill_count == RA_SIZE.

Function
REQ-017 The FSM SHALL have the states IDLE, SETUP, STROBE, RELEASE and FLUSH.
REQ-018 In IDLE with a flush pending, the FSM SHALL enter FLUSH; a pending flush takes priority over every src_req.
REQ-019 In IDLE with no flush pending and any src_req high, the block SHALL grant one source round-robin, latch that source's src_value into ra_value and enter SETUP.
REQ-020 Round-robin search SHALL start at the priority pointer; after each grant the pointer SHALL become (granted+1) mod NUM_SRC.
REQ-021 SETUP SHALL last 1 cycle with ra_data_clk=0, then go to STROBE.
REQ-022 STROBE SHALL last exactly STROBE_CYCLES cycles with ra_data_clk=1, then go to RELEASE.
REQ-023 RELEASE SHALL last 1 cycle with ra_data_clk=0 and src_ack[granted]=1, and SHALL increment fill_count unless it already equals RA_SIZE; next state is IDLE.
REQ-024 Latency: with the request seen in IDLE at cycle 0, SETUP is cycle 1, STROBE is cycles 2..1+STROBE_CYCLES, the ack is at cycle 2+STROBE_CYCLES and IDLE is at cycle 3+STROBE_CYCLES.
REQ-025 Sustained throughput SHALL be one sample per 3+STROBE_CYCLES cycles (5 at the default).
REQ-026 ra_value SHALL hold constant from SETUP through RELEASE; src_value changes after the grant SHALL be ignored.
REQ-027 If src_req of the granted source drops mid-transfer, the transfer SHALL still complete and the ack SHALL still pulse.
REQ-028 A source whose src_req drops before it is granted SHALL NOT be granted or acked.
REQ-029 A flush pulse in any state SHALL set a pending flag, and FLUSH SHALL be taken at the next IDLE; multiple pulses before service SHALL collapse into one.
REQ-030 FLUSH SHALL last 2 cycles with ra_rst=1 and ra_data_clk=0, clear fill_count to 0 and the pending flag, then return to IDLE.
REQ-031 A flush arriving in the same cycle FLUSH exits SHALL remain pending, causing a second FLUSH.
REQ-032 ra_data_clk, ra_rst and src_ack SHALL be driven directly from registers (glitch-free).

Reset
REQ-033 While rst=0, the block SHALL hold: state=IDLE, priority pointer=0, ra_value=0, ra_data_clk=0, ra_rst=0, src_ack=0, fill_count=0, flush pending=0, busy=0.
REQ-034 Reset asserted mid-transfer SHALL immediately abort the transfer, with no ack issued and no fill_count change.

Structure
REQ-035 Package ra_sched_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-036 One sub-module, rr_arbiter, SHALL hold the round-robin grant logic: inputs req vector and pointer; outputs one-hot grant, grant index and valid.

Verification
REQ-037 Single request: src_req=0001, src_value[0]=5'd19 -> ra_value=19, ra_data_clk high in cycles 2-3, src_ack=0001 in cycle 4, fill_count=1.
REQ-038 All requests: src_req=1111 held through 8 transfers -> grant order 0,1,2,3,0,1,2,3, one ack every 5 cycles, window_full=1 after the 8th ack, fill_count stays 8 on the 9th.
REQ-039 Flush: flush pulse during STROBE -> the transfer completes with its ack, then ra_rst=1 for 2 cycles and fill_count=0; two pulses before service -> a single FLUSH.
REQ-040 Flush and request together: flush and src_req=0100 in the same IDLE cycle -> FLUSH first, then source 2 is granted.
REQ-041 Value change: src_value of the granted source changes during STROBE -> ra_value unchanged until RELEASE.
REQ-042 Reset: rst=0 during STROBE -> ra_data_clk=0 with no clock edge needed, no ack, fill_count unchanged at reset release=0, pointer=0.
